// File: rtl/hline_motion_ctrl.sv
// Command-side controller for the horizontal-line Y counter: loads a start row,
// then strobes UP/DW once every (speed+1) frames, reversing at the limit flags.
module hline_motion_ctrl #(
  parameter logic [15:0] START_Y = 16'd320,
  parameter int          BCNT_W  = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              frame_tick,
  input  logic              start,
  input  logic              halt,
  input  logic [3:0]        speed,
  input  logic              y_utc,
  input  logic              y_dtc,
  output logic              UP,
  output logic              DW,
  output logic              LD,
  output logic [15:0]       load_val,
  output logic              dir,
  output logic              busy,
  output logic [BCNT_W-1:0] bounce_cnt
);

  typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

  state_t     state;
  logic [3:0] fcnt;

  localparam logic [BCNT_W-1:0] BCNT_MAX = {BCNT_W{1'b1}};

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      fcnt       <= 4'd0;
      UP         <= 1'b0;
      DW         <= 1'b0;
      LD         <= 1'b0;
      load_val   <= 16'd0;
      dir        <= 1'b0;
      busy       <= 1'b0;
      bounce_cnt <= '0;
    end else begin
      // Strobes are single-cycle: cleared every cycle unless set below.
      UP       <= 1'b0;
      DW       <= 1'b0;
      LD       <= 1'b0;
      load_val <= 16'd0;
      if (halt) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (start) begin
              // Load-cycle outputs are registered on entry so they are visible in LOAD.
              state      <= LOAD;
              LD         <= 1'b1;
              load_val   <= START_Y;
              busy       <= 1'b1;
              dir        <= 1'b0;
              fcnt       <= 4'd0;
              bounce_cnt <= '0;
            end
          end
          LOAD: state <= RUN;
          RUN: begin
            if (frame_tick) begin
              if (fcnt >= speed) begin
                fcnt <= 4'd0;
                // Both limits at once is illegal: step is consumed without a strobe.
                if (!(y_utc && y_dtc)) begin
                  if (!dir) begin
                    if (y_utc) begin
                      dir <= 1'b1;
                      DW  <= 1'b1;
                      if (bounce_cnt != BCNT_MAX) bounce_cnt <= bounce_cnt + 1'b1;
                    end else begin
                      UP <= 1'b1;
                    end
                  end else begin
                    if (y_dtc) begin
                      dir <= 1'b0;
                      UP  <= 1'b1;
                      if (bounce_cnt != BCNT_MAX) bounce_cnt <= bounce_cnt + 1'b1;
                    end else begin
                      DW <= 1'b1;
                    end
                  end
                end
              end else begin
                fcnt <= fcnt + 4'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule
